// File: rtl/gpio_irq_scheduler.sv
// gpio_irq_scheduler: round-robin sequencer that turns the GPIO sticky interrupt
// status into one CPU request at a time (req -> ack -> eoi -> clear pulse), and
// withdraws a request that stays unacked too long so one dead handler cannot
// starve the other sources.
module gpio_irq_scheduler #(
  parameter int NUM_SRC     = 32,
  parameter int ID_W        = $clog2(NUM_SRC),
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] gpio_int_status_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  input  logic               sched_en_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               irq_ack_i,
  input  logic               irq_eoi_i,
  output logic [NUM_SRC-1:0] gpio_int_clr_o,
  output logic               busy_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, SVC, CLR} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               req_q, req_d;
  logic [NUM_SRC-1:0] clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;

  logic [NUM_SRC-1:0] pend;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [ID_W:0]      sum, idx;
  logic [ID_W-1:0]    nxt_id;

  assign pend = gpio_int_status_i & src_en_i;

  // Successor of the current id, wrapping the last source back to 0.
  assign nxt_id = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;

  // Round-robin search: first pending source at or above rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      idx = (sum >= (ID_W+1)'(NUM_SRC)) ? sum - (ID_W+1)'(NUM_SRC) : sum;
      if (!win_vld && pend[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from *_d.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    timer_d  = timer_q;
    req_d    = 1'b0;
    clr_d    = '0;
    tmo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sched_en_i && win_vld) begin
          id_d    = win_id;
          timer_d = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = SVC;
        end else if (!sched_en_i) begin
          state_d = IDLE;
        end else if (!pend[id_q]) begin
          // Source vanished before the CPU claimed it: drop without a clear.
          state_d = IDLE;
        end else if (timer_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          tmo_d    = 1'b1;
          rr_ptr_d = nxt_id;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
          req_d   = 1'b1;
        end
      end
      SVC: begin
        if (irq_eoi_i) begin
          clr_d[id_q] = 1'b1;
          state_d     = CLR;
        end
      end
      CLR: begin
        rr_ptr_d = nxt_id;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      timer_q  <= '0;
      req_q    <= 1'b0;
      clr_q    <= '0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      timer_q  <= timer_d;
      req_q    <= req_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  assign irq_req_o      = req_q;
  assign irq_id_o       = id_q;
  assign gpio_int_clr_o = clr_q;
  assign busy_o         = busy_q;
  assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_gpio_irq_scheduler.sv
// Bench for gpio_irq_scheduler: directed stimulus pushes expected request /
// clear / timeout events into a queue; a forked monitor pops and compares them
// as the DUT produces them. A few cycle-exact checks are made inline.
module tb_gpio_irq_scheduler;
  localparam int N   = 32;
  localparam int IW  = 5;
  localparam int TMO = 4;
  localparam int TW  = 8;

  localparam int K_REQ = 0;
  localparam int K_CLR = 1;
  localparam int K_TMO = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  status, src_en, clr;
  logic          sched_en, req, ack, eoi, busy, tmo;
  logic [IW-1:0] id;
  logic          auto_clr;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  gpio_irq_scheduler #(.NUM_SRC(N), .ID_W(IW), .ACK_TIMEOUT(TMO), .TMO_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .gpio_int_status_i(status), .src_en_i(src_en),
    .sched_en_i(sched_en), .irq_req_o(req), .irq_id_o(id), .irq_ack_i(ack),
    .irq_eoi_i(eoi), .gpio_int_clr_o(clr), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_ev(int k, logic [31:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected event: got kind=%0d val=%0h want none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        bad++;
        $display("FAIL event: got kind=%0d val=%0h want kind=%0d val=%0h", k, v, e.kind, e.val);
      end
    end
  endtask

  task automatic monitor();
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (tmo) mon_ev(K_TMO, 32'h0);
        if (|clr) mon_ev(K_CLR, clr);
        if (req && !prev) mon_ev(K_REQ, 32'(id));
        prev = req;
      end
    end
  endtask

  task automatic wait_req(string nm);
    for (int i = 0; i < 50 && !req; i++) step(1);
    chk(nm, 32'(req), 32'h1);
  endtask

  // Claim the current request, end it, and optionally emulate the GPIO clear.
  task automatic serve();
    wait_req("serve_req");
    ack = 1'b1; step(1); ack = 1'b0;
    step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    if (auto_clr) status = status & ~clr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    status = '0; src_en = '1; sched_en = 1'b1; ack = 1'b0; eoi = 1'b0; auto_clr = 1'b1;
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_clr", clr, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(tmo), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int cnt;
    fork
      monitor();
    join_none

    // 1: basic service, next source by round robin
    do_reset();
    push(K_REQ, 2); push(K_CLR, 32'h4); push(K_REQ, 4); push(K_CLR, 32'h10);
    status = 32'h14;
    step(1);
    chk("t1_req_lat", 32'(req), 1);
    chk("t1_id", 32'(id), 2);
    serve();
    serve();
    step(4);
    chk("t1_idle_busy", 32'(busy), 0);

    // 2: sources 0 and 31 stay pending; service alternates with wrap
    do_reset();
    auto_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(K_REQ, 0);  push(K_CLR, 32'h1);
      push(K_REQ, 31); push(K_CLR, 32'h8000_0000);
    end
    status = 32'h8000_0001;
    for (int i = 0; i < 4; i++) serve();
    status = '0;
    step(4);

    // 3: unacked request withdrawn after ACK_TIMEOUT cycles, then re-requested
    do_reset();
    push(K_REQ, 0); push(K_TMO, 0); push(K_REQ, 0); push(K_CLR, 32'h1);
    status = 32'h1;
    step(1);
    cnt = 0;
    while (req && cnt < 20) begin
      cnt++;
      step(1);
    end
    chk("t3_req_cycles", 32'(cnt), TMO);
    chk("t3_tmo_pulse", 32'(tmo), 1);
    step(1);
    chk("t3_tmo_one_cycle", 32'(tmo), 0);
    chk("t3_rereq", 32'(req), 1);
    serve();
    step(4);

    // 4: source drops while requested -> silent withdrawal
    do_reset();
    push(K_REQ, 3);
    status = 32'h8;
    wait_req("t4_req");
    status = '0;
    step(1);
    chk("t4_req_drop", 32'(req), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_tmo", 32'(tmo), 0);
    step(6);

    // 5: masked sources never request; global disable withdraws
    do_reset();
    src_en = '0;
    status = '1;
    step(5);
    chk("t5_masked_req", 32'(req), 0);
    chk("t5_masked_busy", 32'(busy), 0);
    push(K_REQ, 0);
    src_en = '1;
    wait_req("t5_req");
    sched_en = 1'b0;
    step(1);
    chk("t5_withdraw_req", 32'(req), 0);
    chk("t5_withdraw_busy", 32'(busy), 0);
    status = '0;
    sched_en = 1'b1;
    step(3);

    // 6: asynchronous reset in the middle of service
    do_reset();
    push(K_REQ, 2);
    status = 32'h4;
    wait_req("t6_req");
    ack = 1'b1; step(1); ack = 1'b0;
    #2;
    chk("t6_svc_busy", 32'(busy), 1);
    chk("t6_svc_id", 32'(id), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", 32'(req), 0);
    chk("t6_async_id", 32'(id), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_clr", clr, 0);
    chk("t6_async_tmo", 32'(tmo), 0);
    step(2);
    status = 32'h8000_0001;
    push(K_REQ, 0);  push(K_CLR, 32'h1);
    push(K_REQ, 31); push(K_CLR, 32'h8000_0000);
    rst_n = 1'b1;
    serve();
    serve();
    step(5);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
